rom_loader: RTL

//  Byte-stream program loader; write-side counterpart of the instruction ROM that rv_core fetches from.

---
 rtl/rom_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// Byte-stream program loader: length-prefixed little-endian image into the instruction ROM write port,
// holds the core in reset until loaded. Define LOADER_CSUM_EN to require a trailing XOR checksum byte.
module rom_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_waddr_o,
    output logic [31:0]       rom_wdata_o,
    output logic              core_rst_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        dbg_state_o
);

    localparam logic [2:0] S_LEN  = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_CSUM = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [32:0]     CAP   = 33'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

`ifdef LOADER_CSUM_EN
    localparam logic [2:0] S_TAIL = S_CSUM;
`else
    localparam logic [2:0] S_TAIL = S_DONE;
`endif

    // Handshake: a byte transfers on a rising edge where byte_valid_i and byte_ready_o are both 1.
    logic [2:0]      state;
    logic            live;
    logic [1:0]      byte_cnt;
    logic [31:0]     shreg;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] n_words;
    logic [7:0]      csum;
    logic [31:0]     full_word;
    logic            accept;

    // live keeps ready low for the first cycle after reset release.
    assign byte_ready_o = live && (state == S_LEN || state == S_DATA || state == S_CSUM);
    assign accept       = byte_valid_i && byte_ready_o;
    assign full_word    = {byte_data_i, shreg[31:8]};
    assign dbg_state_o  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_LEN;
            live        <= 1'b0;
            byte_cnt    <= 2'd0;
            shreg       <= 32'd0;
            word_idx    <= '0;
            n_words     <= '0;
            csum        <= 8'd0;
            rom_we_o    <= 1'b0;
            rom_waddr_o <= '0;
            rom_wdata_o <= 32'd0;
            core_rst_o  <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            live     <= 1'b1;
            rom_we_o <= 1'b0;
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= full_word;
            end
            case (state)
                S_LEN: begin
                    if (accept && byte_cnt == 2'd3) begin
                        if (full_word == 32'd0) begin
                            state <= S_TAIL;
                        end else if ({1'b0, full_word} > CAP) begin
                            state <= S_ERR;
                        end else begin
                            state   <= S_DATA;
                            n_words <= full_word[ADDR_W:0];
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum <= csum ^ byte_data_i;
                        if (byte_cnt == 2'd3) begin
                            rom_we_o    <= 1'b1;
                            rom_waddr_o <= word_idx[ADDR_W-1:0];
                            rom_wdata_o <= full_word;
                            word_idx    <= word_idx + ONE_W;
                            if (word_idx + ONE_W == n_words) begin
                                state <= S_TAIL;
                            end
                        end
                    end
                end
`ifdef LOADER_CSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        state <= (byte_data_i == csum) ? S_DONE : S_ERR;
                    end
                end
`endif
                S_DONE: begin
                    done_o     <= 1'b1;
                    core_rst_o <= 1'b1;
                end
                S_ERR: begin
                    err_o <= 1'b1;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule
